// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 character-LCD controller.
//   - lcd_state_e : controller FSM states (init states only with LCD_INIT_EN)
//   - status word and store-data bit positions
//   - power-on init command ROM and clear/home opcode classification
// Optional feature macro: LCD_INIT_EN (adds the power-on init sequence).
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC
`ifdef LCD_INIT_EN
        ,
        INIT_WAIT,
        INIT_CMD
`endif
    } lcd_state_e;

    // status word layout
    localparam int STAT_ON_BIT   = 31;
    localparam int STAT_OVF_BIT  = 8;
    localparam int STAT_BUSY_BIT = 4;
    localparam int STAT_CNT_W    = 3;

    // store data layout
    localparam int WD_ON_BIT   = 31;
    localparam int WD_CTRL_BIT = 30;
    localparam int WD_RS_BIT   = 8;

    // commands that need the long execution wait
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    localparam int INIT_LEN = 4;

    // 8-bit bus, 2 lines; display on; clear; entry mode increment
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: DEPTH x W synchronous command FIFO with show-ahead read.
// Ports:
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   push, din      write request and data; ignored when full
//   pop, dout      read request; dout shows the head entry while not empty
//   count          occupancy, one bit wider than the pointers
//   full, empty    occupancy flags derived from count
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: memory-mapped HD44780 LCD controller. Register stores are queued
// in a small command FIFO and replayed as timed LCD bus write cycles.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_wren, i_wdata LCD register store: [31]=ON [30]=CTRL [8]=RS [7:0]=DATA
//   o_status        [31]=ON [8]=OVF [4]=BUSY [2:0]=FIFO count
//   o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on   LCD pins
// Optional feature macro: LCD_INIT_EN (power-on wait plus init command
// sequence issued from reset before the FIFO is served).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// INIT_WAIT | power-on delay before the init sequence (LCD_INIT_EN only)
// INIT_CMD  | load next init ROM command onto the pins (LCD_INIT_EN only)
// IDLE      | wait for a FIFO entry; pop it onto the pins
// SETUP     | RS/DATA setup before EN rises
// EN_HI     | EN strobe high
// HOLD      | RS/DATA hold after EN falls
// EXEC      | LCD execution wait (long for clear/home)
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWR_CYC   = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wren,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    localparam int T_MAX = max_int(max_int(T_PWR_CYC, T_CLR_CYC),
                                   max_int(T_CMD_CYC, max_int(T_EN_CYC,
                                   max_int(T_SETUP_CYC, T_HOLD_CYC))));
    localparam int CNT_W = $clog2(T_MAX + 1);

    lcd_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cnt_zero;
    logic [7:0]             data_q;
    logic                   rs_q;
    logic                   en_q;
    logic                   on_q;
    logic                   ovf_q;
    logic                   pins_load;
    logic [8:0]             pins_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [8:0]             fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   wdata_unused;

`ifdef LCD_INIT_EN
    logic [2:0]             init_idx_q, init_idx_d;
`endif

    assign wdata_unused = ^i_wdata[29:9];

    // control-only writes never reach the FIFO
    assign fifo_push = i_wren && !i_wdata[WD_CTRL_BIT];

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (9)
    ) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (fifo_push),
        .din   ({i_wdata[WD_RS_BIT], i_wdata[7:0]}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fifo_pop  = 1'b0;
        pins_load = 1'b0;
        pins_d    = fifo_dout;
`ifdef LCD_INIT_EN
        init_idx_d = init_idx_q;
`endif
        case (state_q)
`ifdef LCD_INIT_EN
            INIT_WAIT: begin
                if (cnt_zero) state_d = INIT_CMD;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            INIT_CMD: begin
                pins_load  = 1'b1;
                pins_d     = {1'b0, init_cmd(init_idx_q[1:0])};
                init_idx_d = init_idx_q + 3'd1;
                cnt_d      = CNT_W'(T_SETUP_CYC - 1);
                state_d    = SETUP;
            end
`endif
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    pins_load = 1'b1;
                    cnt_d     = CNT_W'(T_SETUP_CYC - 1);
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = CNT_W'(T_EN_CYC - 1);
                    state_d = EN_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EN_HI: begin
                if (cnt_zero) begin
                    cnt_d   = CNT_W'(T_HOLD_CYC - 1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLR_CYC - 1)
                                                        : CNT_W'(T_CMD_CYC - 1);
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EXEC: begin
                if (cnt_zero) begin
`ifdef LCD_INIT_EN
                    // remaining ROM entries take priority over the FIFO
                    state_d = (init_idx_q < 3'(INIT_LEN)) ? INIT_CMD : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef LCD_INIT_EN
            state_q    <= INIT_WAIT;
            cnt_q      <= CNT_W'(T_PWR_CYC - 1);
            init_idx_q <= '0;
`else
            state_q    <= IDLE;
            cnt_q      <= '0;
`endif
            data_q     <= '0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            on_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
`endif
            if (pins_load) begin
                {rs_q, data_q} <= pins_d;
            end
            // registered so EN is a clean strobe exactly spanning EN_HI
            en_q <= (state_d == EN_HI);
            if (i_wren) begin
                on_q <= i_wdata[WD_ON_BIT];
                if (i_wdata[WD_CTRL_BIT]) ovf_q <= 1'b0;
                else if (fifo_full)       ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        o_status                 = '0;
        o_status[STAT_ON_BIT]    = on_q;
        o_status[STAT_OVF_BIT]   = ovf_q;
        o_status[STAT_BUSY_BIT]  = (state_q != IDLE) || !fifo_empty;
        o_status[STAT_CNT_W-1:0] = STAT_CNT_W'(fifo_count);
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl. A timeline model predicts,
// for every clock, the FIFO contents, the command currently on the pins, the
// EN window and when the controller returns to idle, then compares all
// outputs. Directed scenarios are followed by a randomized phase.
// Honours LCD_INIT_EN when the design is built with it.
module tb_lcd_ctrl;

    localparam int DEPTH = 4;
    localparam int TS    = 2;
    localparam int TE    = 4;
    localparam int TH    = 2;
    localparam int TCMD  = 10;
    localparam int TCLR  = 40;
    localparam int TPWR  = 20;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        wren  = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] status;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .DEPTH       (DEPTH),
        .T_SETUP_CYC (TS),
        .T_EN_CYC    (TE),
        .T_HOLD_CYC  (TH),
        .T_CMD_CYC   (TCMD),
        .T_CLR_CYC   (TCLR),
        .T_PWR_CYC   (TPWR)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wren     (wren),
        .i_wdata    (wdata),
        .o_status   (status),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on)
    );

    // reference model state (cycle-indexed timeline)
    int         t         = 0;
    logic [8:0] q[$];
    int         idle_at   = 0;
    logic [8:0] cur       = '0;
    int         cur_start = -1;
    bit         m_on      = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         m_valid   = 1'b0;
    int         init_n    = 4;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic int exec_len(input logic [8:0] c);
        if (!c[8] && (c[7:0] == 8'h01 || c[7:0] == 8'h02 || c[7:0] == 8'h03)) return TCLR;
        return TCMD;
    endfunction

`ifdef LCD_INIT_EN
    function automatic logic [7:0] rom(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    function automatic bit m_busy();
        return (t < idle_at) || (q.size() != 0) || (init_n < 4);
    endfunction

    function automatic bit m_en();
        return (cur_start >= 0) && (t >= cur_start + TS) && (t < cur_start + TS + TE);
    endfunction

    task automatic check_all();
        logic [31:0] st_e;
        st_e       = '0;
        st_e[31]   = m_on;
        st_e[8]    = m_ovf;
        st_e[4]    = m_busy();
        st_e[2:0]  = 3'(q.size());
        check_eq("status", status, st_e);
        check_eq("en", 32'(lcd_en), 32'(m_en()));
        check_eq("on", 32'(lcd_on), 32'(m_on));
        check_eq("rw", 32'(lcd_rw), 32'(1'b0));
        if (cur_start < 0) begin
            check_eq("pins_rst", {23'b0, lcd_rs, lcd_data}, 32'h0);
        end else if (t >= cur_start && t < idle_at) begin
            check_eq("pins", {23'b0, lcd_rs, lcd_data}, {23'b0, cur});
        end
    endtask

    task automatic model_step(input bit r, input bit w, input logic [31:0] d);
        bit         full_b;
        bit         got;
        logic [8:0] c;
        if (r) begin
            q.delete();
            cur_start = -1;
            m_on      = 1'b0;
            m_ovf     = 1'b0;
            m_valid   = 1'b1;
`ifdef LCD_INIT_EN
            init_n    = 0;
            idle_at   = t + 1 + TPWR;
`else
            init_n    = 4;
            idle_at   = t + 1;
`endif
        end else if (m_valid) begin
            // room is judged on occupancy at the start of the cycle
            full_b = (q.size() >= DEPTH);
            got    = 1'b0;
            c      = '0;
            if (t >= idle_at) begin
`ifdef LCD_INIT_EN
                if (init_n < 4) begin
                    c = {1'b0, rom(init_n)};
                    init_n++;
                    got = 1'b1;
                end else
`endif
                if (q.size() > 0) begin
                    c   = q.pop_front();
                    got = 1'b1;
                end
                if (got) begin
                    cur       = c;
                    cur_start = t + 1;
                    idle_at   = t + 1 + TS + TE + TH + exec_len(c);
                end
            end
            if (w) begin
                m_on = d[31];
                if (d[30])       m_ovf = 1'b0;
                else if (full_b) m_ovf = 1'b1;
                else             q.push_back({d[8], d[7:0]});
            end
        end
        t++;
    endtask

    task automatic cyc(input bit r, input bit w, input logic [31:0] d);
        @(negedge clk);
        if (m_valid) check_all();
        rst   = r;
        wren  = w;
        wdata = d;
        model_step(r, w, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 3000 && m_busy(); i++) cyc(1'b0, 1'b0, 32'h0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
        // a store issued during the init sequence must wait for it
        cyc(1'b0, 1'b1, 32'h8000_0141);
        wait_quiet();

        // single data write: pins from +2, EN at +4..+7, idle at +20
        cyc(1'b0, 1'b1, 32'h8000_0141);
        idle(25);

        // clear command: long execution wait
        cyc(1'b0, 1'b1, 32'h0000_0001);
        wait_quiet();

        // burst of six back-to-back writes: the last one overflows
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 32'h8000_0150 + 32'(i));
        idle(10);
        cyc(1'b0, 1'b1, 32'h4000_0000);
        wait_quiet();

        // full FIFO write coinciding with a pop is dropped, count ends at 3
        cyc(1'b0, 1'b1, 32'h8000_0160);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b1, 32'h8000_0160 + 32'(i));
        for (int i = 0; i < 100 && t < idle_at; i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h8000_016F);
        idle(3);
        cyc(1'b0, 1'b1, 32'hC000_0000);
        wait_quiet();

        // reset while EN is high with commands queued
        cyc(1'b0, 1'b1, 32'h8000_0170);
        cyc(1'b0, 1'b1, 32'h8000_0171);
        cyc(1'b0, 1'b1, 32'h8000_0172);
        for (int i = 0; i < 50 && !m_en(); i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        idle(40);
        wait_quiet();

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            d      = $urandom;
            d[30]  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                d[8]   = 1'b0;
                d[7:0] = 8'($urandom_range(1, 3));
            end
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), d);
        end
        wait_quiet();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Memory-mapped HD44780 character-LCD controller that consumes the 32-bit LCD register stores issued by the load/store unit and turns each one into a correctly timed LCD bus write cycle. A small command FIFO decouples the single-cycle core from multi-microsecond LCD timing. A status word is returned to the LSU read mux so software can poll busy, FIFO level and overflow. Sits between the LSU output-region decode and the board LCD pins.

## Interface
- DEPTH, 4: command FIFO entries (power of 2, ≥2)
- T_SETUP_CYC, 2: RS/DATA setup before EN rise, in clocks
- T_EN_CYC, 12: EN high width, in clocks
- T_HOLD_CYC, 2: RS/DATA hold after EN fall, in clocks
- T_CMD_CYC, 2000: execution wait for normal commands/data (40 µs at 50 MHz)
- T_CLR_CYC, 82000: execution wait for clear/home (1.64 ms)
- T_PWR_CYC, 750000: power-on wait before init (15 ms); used only with LCD_INIT_EN
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wren  in  1  LSU store hits LCD register (write enable already qualified by address decode)
- i_wdata  in  32  store data: [31]=ON, [30]=CTRL (control-only write), [8]=RS, [7:0]=DATA
- o_status  out  32  read data: [31]=ON, [8]=OVF, [4]=BUSY, [2:0]=FIFO count (zero elsewhere)
- o_lcd_data  out  8  LCD DB7..DB0
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD R/W, constant 0 (write-only)
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_on  out  1  LCD power/backlight enable

## Operation
- Write, CTRL=1: ON register ← wdata[31]; OVF cleared; nothing enqueued.
- Write, CTRL=0: ON ← wdata[31]; {RS, DATA} enqueued if count < DEPTH, else dropped and OVF set (sticky).
- Full check uses count at the start of the cycle; a pop in the same cycle does not make room.
- FSM states: INIT_WAIT, INIT_CMD, IDLE, SETUP, EN_HI, HOLD, EXEC.
- IDLE: FIFO non-empty → pop, register RS/DATA onto pins, → SETUP.
- SETUP T_SETUP_CYC → EN_HI (EN=1) T_EN_CYC → HOLD (EN=0) T_HOLD_CYC → EXEC.
- EXEC waits T_CLR_CYC if RS=0 and DATA ∈ {0x01, 0x02, 0x03}, else T_CMD_CYC; then → IDLE (or INIT_CMD during init).
- RS/DATA are stable from SETUP entry through end of EXEC.
- BUSY = (state ≠ IDLE) or FIFO non-empty.
- Single down-counter shared by all timed states, sized for max(T_PWR_CYC, T_CLR_CYC).
- Reset, including mid-transfer: FIFO emptied, OVF=0, ON=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_en=0, o_lcd_rw=0. Interrupted command lost; state → INIT_WAIT (macro on) or IDLE (macro off).

## Timing
- Store in cycle 0 into empty FIFO, FSM idle: entry visible in cycle 1; pins carry RS/DATA from cycle 2.
- o_lcd_en high in cycles 2+T_SETUP_CYC through 2+T_SETUP_CYC+T_EN_CYC−1.
- FSM back in IDLE after T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+T_exec cycles; next entry is popped in that IDLE cycle.
- o_status is registered except BUSY and count, which reflect the current state and pointers (combinational from registers).
- Accepted-write throughput: one per clock into FIFO; drain one per LCD cycle.

## Configuration
- LCD_INIT_EN defined: reset → INIT_WAIT for T_PWR_CYC, then INIT_CMD issues 0x38, 0x0C, 0x01, 0x06 (RS=0) from an internal ROM through the SETUP..EXEC path, then IDLE. FIFO accepts writes during init; BUSY=1 from reset.
- Not defined: INIT states absent; reset → IDLE, BUSY=0; software initializes the LCD.

## Structure
- lcd_pkg: state enum, status bit-position constants, wdata field positions, init command ROM constants, clear/home opcode constants.
- Sub-module lcd_cmd_fifo: DEPTH×9-bit synchronous FIFO with push, pop, count, full, and empty. Pointers wrap modulo DEPTH; count is one bit wider.

## Test plan
Sim parameters: T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=40, DEPTH=4, T_PWR=20.
- Macro off, write 0x8000_0141 at cycle 0 → data=0x41, rs=1 from cycle 2; en high cycles 4–7; BUSY falls at cycle 20; o_lcd_on=1.
- Write 0x0000_0001 (clear) → EXEC lasts 40 cycles; BUSY high 48 cycles after pop.
- Five back-to-back data writes with FSM busy → first popped, four queued; if the fifth arrives while count=4, it is dropped, OVF=1, status[8]=1. A later write 0x4000_0000 clears OVF with no new LCD cycle.
- Reset asserted while en=1 → next cycle en=0, data=0, count=0, on=0; queued commands never appear on pins.
- Macro on, release reset → 20 idle cycles, then en pulses carrying 0x38, 0x0C, 0x01, 0x06 in order. A write queued during init is issued after 0x06.
- Write full at count=4 coinciding with pop → write dropped, OVF=1, count ends at 3.
